// File: rtl/rob_gen2.sv
// Reorder buffer with count-based full/empty, flush squash and an older-store load check.
// Optional store-to-load forwarding outputs are enabled by defining ROB_STLF_EN.
module rob_gen2 #(
   parameter int ROB_SIZE = 8,
   parameter int XLEN     = 32,
   parameter int TAG_W    = $clog2(ROB_SIZE)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic              alloc_en,
   input  logic              alloc_wr_mem,
   input  logic [4:0]        alloc_dest_reg,
   input  logic [2:0]        alloc_mem_size,
   input  logic [XLEN-1:0]   alloc_value,
   input  logic              alloc_value_valid,
   input  logic [TAG_W-1:0]  alloc_store_dep,
   output logic              alloc_ready,
   output logic [TAG_W-1:0]  alloc_tag,
   input  logic              cdb_valid,
   input  logic [TAG_W-1:0]  cdb_tag,
   input  logic [XLEN-1:0]   cdb_value,
   input  logic [TAG_W-1:0]  rd_tag_rs1,
   input  logic [TAG_W-1:0]  rd_tag_rs2,
   output logic [XLEN-1:0]   rd_value_rs1,
   output logic [XLEN-1:0]   rd_value_rs2,
   output logic              rd_ready_rs1,
   output logic              rd_ready_rs2,
   input  logic [TAG_W-1:0]  ld_check_tag,
   input  logic [XLEN-1:0]   ld_check_addr,
   output logic              ld_conflict,
`ifdef ROB_STLF_EN
   output logic              ld_fwd_valid,
   output logic [XLEN-1:0]   ld_fwd_value,
`endif
   output logic              head_valid,
   output logic              head_ready,
   output logic [TAG_W-1:0]  head_tag,
   output logic [4:0]        head_dest_reg,
   output logic [XLEN-1:0]   head_value,
   output logic [XLEN-1:0]   head_addr,
   output logic              head_wr_mem,
   output logic [2:0]        head_mem_size,
   input  logic              commit,
   output logic [TAG_W:0]    count,
   output logic              empty,
   output logic [4:0]        wb_dest_reg,
   output logic              wb_valid
);

   logic [ROB_SIZE-1:0] valid_q, valid_d, wr_mem_q, wr_mem_d;
   logic [ROB_SIZE-1:0] value_ready_q, value_ready_d, addr_ready_q, addr_ready_d;
   logic [4:0]          dest_reg_q  [ROB_SIZE];
   logic [4:0]          dest_reg_d  [ROB_SIZE];
   logic [XLEN-1:0]     value_q     [ROB_SIZE];
   logic [XLEN-1:0]     value_d     [ROB_SIZE];
   logic [XLEN-1:0]     addr_q      [ROB_SIZE];
   logic [XLEN-1:0]     addr_d      [ROB_SIZE];
   logic [TAG_W-1:0]    store_dep_q [ROB_SIZE];
   logic [TAG_W-1:0]    store_dep_d [ROB_SIZE];
   logic [2:0]          mem_size_q  [ROB_SIZE];
   logic [2:0]          mem_size_d  [ROB_SIZE];
   logic [TAG_W-1:0]    head_q, head_d, tail_q, tail_d;
   logic [TAG_W:0]      count_q, count_d;

   logic retire, alloc_fire, cdb_hit;

   assign head_ready  = valid_q[head_q] && value_ready_q[head_q] && addr_ready_q[head_q];
   assign retire      = commit && head_ready;
   assign alloc_ready = (count_q < (TAG_W+1)'(ROB_SIZE)) || retire;
   assign alloc_fire  = alloc_en && alloc_ready;
   assign cdb_hit     = cdb_valid && valid_q[cdb_tag];

   always_comb begin
      valid_d       = valid_q;
      wr_mem_d      = wr_mem_q;
      value_ready_d = value_ready_q;
      addr_ready_d  = addr_ready_q;
      dest_reg_d    = dest_reg_q;
      value_d       = value_q;
      addr_d        = addr_q;
      store_dep_d   = store_dep_q;
      mem_size_d    = mem_size_q;
      head_d        = head_q;
      tail_d        = tail_q;
      count_d       = count_q;
      if (flush) begin
         valid_d       = '0;
         value_ready_d = '0;
         addr_ready_d  = '0;
         head_d        = '0;
         tail_d        = '0;
         count_d       = '0;
      end else begin
         // Producer result: stores take it as their address, others as their value.
         if (cdb_hit) begin
            if (wr_mem_q[cdb_tag]) begin
               addr_d[cdb_tag]       = cdb_value;
               addr_ready_d[cdb_tag] = 1'b1;
            end else begin
               value_d[cdb_tag]       = cdb_value;
               value_ready_d[cdb_tag] = 1'b1;
            end
            for (int i = 0; i < ROB_SIZE; i++) begin
               if (valid_q[i] && wr_mem_q[i] && !value_ready_q[i] && store_dep_q[i] == cdb_tag) begin
                  value_d[i]       = cdb_value;
                  value_ready_d[i] = 1'b1;
               end
            end
         end
         if (retire) begin
            valid_d[head_q]       = 1'b0;
            value_ready_d[head_q] = 1'b0;
            addr_ready_d[head_q]  = 1'b0;
            head_d                = head_q + TAG_W'(1);
         end
         // Allocation is applied last so it wins over a same-slot retire clear.
         if (alloc_fire) begin
            valid_d[tail_q]      = 1'b1;
            wr_mem_d[tail_q]     = alloc_wr_mem;
            dest_reg_d[tail_q]   = alloc_dest_reg;
            mem_size_d[tail_q]   = alloc_mem_size;
            store_dep_d[tail_q]  = alloc_store_dep;
            addr_d[tail_q]       = '0;
            addr_ready_d[tail_q] = !alloc_wr_mem;
            if (alloc_wr_mem && alloc_value_valid) begin
               value_d[tail_q]       = alloc_value;
               value_ready_d[tail_q] = 1'b1;
            end else if (alloc_wr_mem && cdb_valid && cdb_tag == alloc_store_dep) begin
               value_d[tail_q]       = cdb_value;
               value_ready_d[tail_q] = 1'b1;
            end else begin
               value_d[tail_q]       = '0;
               value_ready_d[tail_q] = 1'b0;
            end
            tail_d = tail_q + TAG_W'(1);
         end
         count_d = count_q + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(retire);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q       <= '0;
         wr_mem_q      <= '0;
         value_ready_q <= '0;
         addr_ready_q  <= '0;
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
      end else begin
         valid_q       <= valid_d;
         wr_mem_q      <= wr_mem_d;
         value_ready_q <= value_ready_d;
         addr_ready_q  <= addr_ready_d;
         head_q        <= head_d;
         tail_q        <= tail_d;
         count_q       <= count_d;
      end
   end

   // Payload storage is qualified by the flags above and needs no reset.
   always_ff @(posedge clock) begin
      dest_reg_q  <= dest_reg_d;
      value_q     <= value_d;
      addr_q      <= addr_d;
      store_dep_q <= store_dep_d;
      mem_size_q  <= mem_size_d;
   end

   logic [TAG_W-1:0] ld_dist, scan_idx;
   logic             ld_live, older_conflict;

   assign ld_dist = ld_check_tag - head_q;
   assign ld_live = valid_q[ld_check_tag];

   // Entries at distance d < ld_dist from head are older than the load.
   always_comb begin
      older_conflict = 1'b0;
      scan_idx       = '0;
      for (int d = 0; d < ROB_SIZE; d++) begin
         scan_idx = head_q + TAG_W'(d);
         if (ld_live && TAG_W'(d) < ld_dist && valid_q[scan_idx] && wr_mem_q[scan_idx] &&
             (!addr_ready_q[scan_idx] || addr_q[scan_idx] == ld_check_addr))
            older_conflict = 1'b1;
      end
   end

`ifdef ROB_STLF_EN
   logic [TAG_W-1:0] fwd_idx;
   logic             fwd_hit, unk_after;
   logic [XLEN-1:0]  fwd_val;

   // Oldest-to-youngest walk: the last address match wins, unknown addresses after it block.
   always_comb begin
      fwd_hit   = 1'b0;
      unk_after = 1'b0;
      fwd_val   = '0;
      fwd_idx   = '0;
      for (int d = 0; d < ROB_SIZE; d++) begin
         fwd_idx = head_q + TAG_W'(d);
         if (ld_live && TAG_W'(d) < ld_dist && valid_q[fwd_idx] && wr_mem_q[fwd_idx]) begin
            if (!addr_ready_q[fwd_idx]) begin
               unk_after = 1'b1;
            end else if (addr_q[fwd_idx] == ld_check_addr) begin
               unk_after = 1'b0;
               fwd_hit   = value_ready_q[fwd_idx] && mem_size_q[fwd_idx] == mem_size_q[ld_check_tag];
               fwd_val   = value_q[fwd_idx];
            end
         end
      end
   end

   assign ld_fwd_valid = fwd_hit && !unk_after;
   assign ld_fwd_value = fwd_val;
   assign ld_conflict  = older_conflict && !ld_fwd_valid;
`else
   assign ld_conflict  = older_conflict;
`endif

   assign alloc_tag     = tail_q;
   assign count         = count_q;
   assign empty         = (count_q == '0);
   assign head_valid    = valid_q[head_q];
   assign head_tag      = head_q;
   assign head_dest_reg = dest_reg_q[head_q];
   assign head_value    = value_q[head_q];
   assign head_addr     = addr_q[head_q];
   assign head_wr_mem   = wr_mem_q[head_q];
   assign head_mem_size = mem_size_q[head_q];
   assign rd_value_rs1  = value_q[rd_tag_rs1];
   assign rd_value_rs2  = value_q[rd_tag_rs2];
   assign rd_ready_rs1  = value_ready_q[rd_tag_rs1];
   assign rd_ready_rs2  = value_ready_q[rd_tag_rs2];
   assign wb_dest_reg   = dest_reg_q[cdb_tag];
   assign wb_valid      = cdb_valid;

endmodule

// File: tb/tb_rob_gen2.sv
// Bench for rob_gen2: directed scenarios then random traffic against a program-order queue model.
module tb_rob_gen2;
   localparam int N  = 8;
   localparam int XL = 32;
   localparam int TW = 3;

   logic clock = 1'b0;
   logic reset, flush, alloc_en, alloc_wr_mem, alloc_value_valid;
   logic [4:0] alloc_dest_reg;
   logic [2:0] alloc_mem_size;
   logic [XL-1:0] alloc_value;
   logic [TW-1:0] alloc_store_dep;
   logic alloc_ready;
   logic [TW-1:0] alloc_tag;
   logic cdb_valid;
   logic [TW-1:0] cdb_tag;
   logic [XL-1:0] cdb_value;
   logic [TW-1:0] rd_tag_rs1, rd_tag_rs2;
   logic [XL-1:0] rd_value_rs1, rd_value_rs2;
   logic rd_ready_rs1, rd_ready_rs2;
   logic [TW-1:0] ld_check_tag;
   logic [XL-1:0] ld_check_addr;
   logic ld_conflict;
   logic head_valid, head_ready, head_wr_mem;
   logic [TW-1:0] head_tag;
   logic [4:0] head_dest_reg;
   logic [XL-1:0] head_value, head_addr;
   logic [2:0] head_mem_size;
   logic commit;
   logic [TW:0] count;
   logic empty;
   logic [4:0] wb_dest_reg;
   logic wb_valid;

   rob_gen2 #(.ROB_SIZE(N), .XLEN(XL)) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .alloc_en(alloc_en), .alloc_wr_mem(alloc_wr_mem), .alloc_dest_reg(alloc_dest_reg),
      .alloc_mem_size(alloc_mem_size), .alloc_value(alloc_value),
      .alloc_value_valid(alloc_value_valid), .alloc_store_dep(alloc_store_dep),
      .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .rd_tag_rs1(rd_tag_rs1), .rd_tag_rs2(rd_tag_rs2),
      .rd_value_rs1(rd_value_rs1), .rd_value_rs2(rd_value_rs2),
      .rd_ready_rs1(rd_ready_rs1), .rd_ready_rs2(rd_ready_rs2),
      .ld_check_tag(ld_check_tag), .ld_check_addr(ld_check_addr), .ld_conflict(ld_conflict),
      .head_valid(head_valid), .head_ready(head_ready), .head_tag(head_tag),
      .head_dest_reg(head_dest_reg), .head_value(head_value), .head_addr(head_addr),
      .head_wr_mem(head_wr_mem), .head_mem_size(head_mem_size),
      .commit(commit), .count(count), .empty(empty),
      .wb_dest_reg(wb_dest_reg), .wb_valid(wb_valid)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [TW-1:0] tag;
      logic          wr_mem;
      logic [4:0]    dest;
      logic [2:0]    size;
      logic [XL-1:0] value;
      logic          vrdy;
      logic [XL-1:0] addr;
      logic          ardy;
      logic [TW-1:0] dep;
   } ent_t;

   typedef struct {
      logic [TW-1:0] tag;
      logic          wr_mem;
      logic [4:0]    dest;
      logic [2:0]    size;
   } ret_t;

   ent_t mq[$];     // in-flight instructions, oldest first
   ret_t exp_q[$];  // expected retirement order
   int   tail_m = 0;
   int   total = 0;
   int   bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int find(input logic [TW-1:0] t);
      foreach (mq[i]) if (mq[i].tag == t) return i;
      return -1;
   endfunction

   function automatic logic exp_conflict();
      int   p = find(ld_check_tag);
      logic c = 1'b0;
      for (int k = 0; k < p; k++)
         if (mq[k].wr_mem && (!mq[k].ardy || mq[k].addr == ld_check_addr)) c = 1'b1;
      return c;
   endfunction

   function automatic logic exp_head_ready();
      return mq.size() > 0 && mq[0].vrdy && mq[0].ardy;
   endfunction

   task automatic check_comb();
      int   n = mq.size();
      logic hr = exp_head_ready();
      int   i1, i2, ic;
      chk("count", 64'(count), 64'(n));
      chk("empty", 64'(empty), 64'(n == 0));
      chk("head_valid", 64'(head_valid), 64'(n > 0));
      chk("head_ready", 64'(head_ready), 64'(hr));
      chk("alloc_tag", 64'(alloc_tag), 64'(tail_m));
      chk("alloc_ready", 64'(alloc_ready), 64'(n < N || (commit && hr)));
      if (n > 0) begin
         chk("head_tag", 64'(head_tag), 64'(mq[0].tag));
         chk("head_dest", 64'(head_dest_reg), 64'(mq[0].dest));
         chk("head_wr_mem", 64'(head_wr_mem), 64'(mq[0].wr_mem));
         chk("head_size", 64'(head_mem_size), 64'(mq[0].size));
         if (mq[0].vrdy) chk("head_value", 64'(head_value), 64'(mq[0].value));
         if (mq[0].wr_mem && mq[0].ardy) chk("head_addr", 64'(head_addr), 64'(mq[0].addr));
      end
      chk("ld_conflict", 64'(ld_conflict), 64'(exp_conflict()));
      i1 = find(rd_tag_rs1);
      i2 = find(rd_tag_rs2);
      chk("rd_ready1", 64'(rd_ready_rs1), 64'(i1 >= 0 && mq[i1].vrdy));
      chk("rd_ready2", 64'(rd_ready_rs2), 64'(i2 >= 0 && mq[i2].vrdy));
      if (i1 >= 0 && mq[i1].vrdy) chk("rd_value1", 64'(rd_value_rs1), 64'(mq[i1].value));
      if (i2 >= 0 && mq[i2].vrdy) chk("rd_value2", 64'(rd_value_rs2), 64'(mq[i2].value));
      chk("wb_valid", 64'(wb_valid), 64'(cdb_valid));
      ic = find(cdb_tag);
      if (cdb_valid && ic >= 0) chk("wb_dest", 64'(wb_dest_reg), 64'(mq[ic].dest));
   endtask

   // Applies the architectural effect of one clock edge to the queue model.
   task automatic model_edge();
      logic ret, aok, cap;
      int   ci;
      ent_t e;
      if (reset || flush) begin
         mq.delete();
         exp_q.delete();
         tail_m = 0;
         return;
      end
      ret = commit && exp_head_ready();
      aok = alloc_en && (mq.size() < N || ret);
      if (cdb_valid) begin
         ci = find(cdb_tag);
         if (ci >= 0) begin
            if (mq[ci].wr_mem) begin
               mq[ci].addr = cdb_value; mq[ci].ardy = 1'b1;
            end else begin
               mq[ci].value = cdb_value; mq[ci].vrdy = 1'b1;
            end
            foreach (mq[i])
               if (mq[i].wr_mem && !mq[i].vrdy && mq[i].dep == cdb_tag) begin
                  mq[i].value = cdb_value; mq[i].vrdy = 1'b1;
               end
         end
      end
      if (ret) void'(mq.pop_front());
      if (aok) begin
         cap      = alloc_wr_mem && !alloc_value_valid && cdb_valid && cdb_tag == alloc_store_dep;
         e.tag    = TW'(tail_m);
         e.wr_mem = alloc_wr_mem;
         e.dest   = alloc_dest_reg;
         e.size   = alloc_mem_size;
         e.dep    = alloc_store_dep;
         e.addr   = '0;
         e.ardy   = !alloc_wr_mem;
         e.vrdy   = alloc_wr_mem && (alloc_value_valid || cap);
         e.value  = !alloc_wr_mem ? '0 : (alloc_value_valid ? alloc_value : (cap ? cdb_value : '0));
         mq.push_back(e);
         exp_q.push_back('{e.tag, e.wr_mem, e.dest, e.size});
         tail_m = (tail_m + 1) % N;
      end
   endtask

   // Inputs are set just after a falling edge; checks land 2 units later.
   task automatic cyc();
      #2;
      if (!reset) check_comb();
      @(posedge clock);
      model_edge();
      @(negedge clock);
   endtask

   task automatic idle();
      reset = 0; flush = 0; alloc_en = 0; alloc_wr_mem = 0; alloc_dest_reg = '0;
      alloc_mem_size = '0; alloc_value = '0; alloc_value_valid = 0; alloc_store_dep = '0;
      cdb_valid = 0; cdb_tag = '0; cdb_value = '0; rd_tag_rs1 = '0; rd_tag_rs2 = '0;
      ld_check_tag = '0; ld_check_addr = '0; commit = 0;
   endtask

   task automatic set_alloc(input logic st, input logic [4:0] dr, input logic vv,
                            input logic [XL-1:0] v, input logic [TW-1:0] dep);
      alloc_en = 1; alloc_wr_mem = st; alloc_dest_reg = dr; alloc_mem_size = 3'd2;
      alloc_value_valid = vv; alloc_value = v; alloc_store_dep = dep;
   endtask

   // Retirement scoreboard: whenever the DUT retires, the oldest expected entry must match.
   ret_t r;
   always begin
      @(negedge clock);
      #2;
      if (!reset && !flush && commit && head_valid && head_ready) begin
         if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL retire_order: DUT retired tag %0d, nothing expected", head_tag);
         end else begin
            r = exp_q.pop_front();
            chk("ret_tag", 64'(head_tag), 64'(r.tag));
            chk("ret_dest", 64'(head_dest_reg), 64'(r.dest));
            chk("ret_wr_mem", 64'(head_wr_mem), 64'(r.wr_mem));
            chk("ret_size", 64'(head_mem_size), 64'(r.size));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      reset = 1;
      @(negedge clock);
      cyc(); cyc();
      idle();
      #1;
      chk("rst_alloc_ready", 64'(alloc_ready), 64'(1));
      chk("rst_empty", 64'(empty), 64'(1));
      chk("rst_head_valid", 64'(head_valid), 64'(0));
      chk("rst_head_ready", 64'(head_ready), 64'(0));
      chk("rst_ld_conflict", 64'(ld_conflict), 64'(0));
      chk("rst_alloc_tag", 64'(alloc_tag), 64'(0));

      // Fill all eight slots.
      for (int i = 0; i < N; i++) begin
         idle(); set_alloc(1'b0, 5'(i + 1), 1'b0, '0, '0);
         #1 chk("fill_tag", 64'(alloc_tag), 64'(i));
         cyc();
      end
      chk("full_count", 64'(count), 64'(8));
      chk("full_alloc_ready", 64'(alloc_ready), 64'(0));
      idle(); set_alloc(1'b0, 5'd9, 1'b0, '0, '0);
      cyc();
      chk("full_ignored_tail", 64'(alloc_tag), 64'(0));
      chk("full_ignored_count", 64'(count), 64'(8));

      // Retire and allocate together while full.
      idle(); cdb_valid = 1; cdb_tag = 3'd0; cdb_value = 32'h11;
      cyc();
      idle(); commit = 1; set_alloc(1'b0, 5'd10, 1'b0, '0, '0);
      #1 chk("full_retire_alloc_ready", 64'(alloc_ready), 64'(1));
      cyc();
      chk("full_retire_head", 64'(head_tag), 64'(1));
      chk("full_retire_count", 64'(count), 64'(8));
      idle(); flush = 1; cyc();

      // Store data captured from the CDB in its dispatch cycle.
      for (int i = 0; i < 4; i++) begin
         idle(); set_alloc(1'b0, 5'(i + 1), 1'b0, '0, '0); cyc();
      end
      idle(); set_alloc(1'b1, 5'd0, 1'b0, '0, 3'd3);
      cdb_valid = 1; cdb_tag = 3'd3; cdb_value = 32'hDEAD;
      cyc();
      idle(); rd_tag_rs1 = 3'd4;
      #1 chk("dispatch_capture_rdy", 64'(rd_ready_rs1), 64'(1));
      chk("dispatch_capture_val", 64'(rd_value_rs1), 64'(32'hDEAD));
      cyc();
      idle(); flush = 1; cyc();

      // Load at tag 4 against an older store at tag 2.
      for (int i = 0; i < 5; i++) begin
         idle(); set_alloc(i == 2, 5'(i + 1), 1'b1, 32'h55, '0); cyc();
      end
      idle(); ld_check_tag = 3'd4; ld_check_addr = 32'h100;
      #1 chk("ld_addr_unknown", 64'(ld_conflict), 64'(1));
      cyc();
      idle(); cdb_valid = 1; cdb_tag = 3'd2; cdb_value = 32'h100; cyc();
      idle(); ld_check_tag = 3'd4; ld_check_addr = 32'h100;
      #1 chk("ld_addr_match", 64'(ld_conflict), 64'(1));
      cyc();
      idle(); ld_check_tag = 3'd4; ld_check_addr = 32'h104;
      #1 chk("ld_addr_differ", 64'(ld_conflict), 64'(0));
      cyc();
      idle(); ld_check_tag = 3'd0; ld_check_addr = 32'h100;
      #1 chk("ld_at_head", 64'(ld_conflict), 64'(0));
      cyc();
      idle(); ld_check_tag = 3'd6; ld_check_addr = 32'h100;
      #1 chk("ld_invalid", 64'(ld_conflict), 64'(0));
      cyc();

      // Flush with five pending entries plus alloc and CDB in the same cycle.
      idle(); flush = 1; set_alloc(1'b0, 5'd7, 1'b0, '0, '0);
      cdb_valid = 1; cdb_tag = 3'd1; cdb_value = 32'h77;
      cyc();
      chk("flush_count", 64'(count), 64'(0));
      chk("flush_empty", 64'(empty), 64'(1));
      chk("flush_head_valid", 64'(head_valid), 64'(0));
      chk("flush_alloc_tag", 64'(alloc_tag), 64'(0));

      // Wrap the pointers with alloc/complete/commit triples.
      for (int i = 0; i < 20; i++) begin
         idle(); set_alloc(1'b0, 5'(i + 1), 1'b0, '0, '0);
         #1 chk("wrap_tag", 64'(alloc_tag), 64'(i % N));
         cyc();
         idle(); cdb_valid = 1; cdb_tag = 3'(i % N); cdb_value = 32'(i); cyc();
         idle(); commit = 1; cyc();
      end
      chk("wrap_count", 64'(count), 64'(0));
      chk("wrap_empty", 64'(empty), 64'(1));

      // Random traffic.
      for (int c = 0; c < 3000; c++) begin
         idle();
         reset    = ($urandom_range(0, 999) < 5);
         flush    = ($urandom_range(0, 99) < 2);
         alloc_en = ($urandom_range(0, 99) < 60);
         alloc_wr_mem      = ($urandom_range(0, 2) == 0);
         alloc_dest_reg    = 5'($urandom);
         alloc_mem_size    = 3'($urandom);
         alloc_value       = $urandom;
         alloc_value_valid = ($urandom_range(0, 1) == 1);
         alloc_store_dep   = mq.size() > 0 ? mq[$urandom_range(0, mq.size() - 1)].tag
                                           : TW'($urandom_range(0, N - 1));
         cdb_valid = ($urandom_range(0, 99) < 70);
         cdb_tag   = (mq.size() > 0 && $urandom_range(0, 9) < 9) ? mq[$urandom_range(0, mq.size() - 1)].tag
                                                                 : TW'($urandom_range(0, N - 1));
         if ($urandom_range(0, 3) == 0) cdb_tag = alloc_store_dep;
         cdb_value     = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 7) * 4);
         ld_check_tag  = mq.size() > 0 ? mq[$urandom_range(0, mq.size() - 1)].tag
                                       : TW'($urandom_range(0, N - 1));
         ld_check_addr = 32'($urandom_range(0, 7) * 4);
         rd_tag_rs1    = TW'($urandom_range(0, N - 1));
         rd_tag_rs2    = TW'($urandom_range(0, N - 1));
         commit        = ($urandom_range(0, 1) == 1);
         cyc();
      end
      idle(); cyc(); cyc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/rob_gen2.md
Name: rob_gen2

Overview:
Parametrised second-generation reorder buffer for the out-of-order core. Tracks in-flight instructions in program order, captures CDB results and store address/data, and retires the head in order through a commit handshake. Adds three things: a count-based full/empty, a pipeline flush for mispredict squash, and a load-ordering check that considers only stores older than the load. Sits between dispatch, the CDB, the map table and the LSQ/commit stage.

Parameters:
ROB_SIZE, 8, number of entries; power of two, minimum 2
XLEN, 32, data/address width
TAG_W, $clog2(ROB_SIZE), tag width; tags are 0-based, 0..ROB_SIZE-1

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
flush  in  1  squash all entries (mispredict)
alloc_en  in  1  dispatch requests an entry
alloc_wr_mem  in  1  new instruction is a store
alloc_dest_reg  in  5  destination arch register (0 = none)
alloc_mem_size  in  3  store/load size code
alloc_value  in  XLEN  store data if known
alloc_value_valid  in  1  store data known at dispatch
alloc_store_dep  in  TAG_W  producer tag of store data
alloc_ready  out  1  entry available (!full)
alloc_tag  out  TAG_W  tag given to the allocating instruction
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  CDB producer tag
cdb_value  in  XLEN  CDB value (address for stores)
rd_tag_rs1/rs2  in  TAG_W  operand read tags
rd_value_rs1/rs2  out  XLEN  entry value
rd_ready_rs1/rs2  out  1  entry value_ready
ld_check_tag  in  TAG_W  tag of load being checked
ld_check_addr  in  XLEN  load address
ld_conflict  out  1  older store has matching or unknown address
head_valid  out  1  head entry occupied
head_ready  out  1  head complete
head_tag  out  TAG_W  head index
head_dest_reg  out  5  head destination register
head_value  out  XLEN  head value or store data
head_addr  out  XLEN  head store address
head_wr_mem  out  1  head is a store
head_mem_size  out  3  head size code
commit  in  1  commit stage retires head; ignored unless head_ready
count  out  TAG_W+1  occupied entries
empty  out  1  count==0
wb_dest_reg  out  5  dest_reg of entry cdb_tag (map-table clear)
wb_valid  out  1  equals cdb_valid

Behaviour:
- Reset: head=tail=0, count=0, every entry invalid. Outputs after reset: alloc_ready=1, empty=1, head_valid=0, head_ready=0, ld_conflict=0, alloc_tag=0.
- Entry fields: valid, wr_mem, dest_reg, value, value_ready, addr, addr_ready, store_dep, mem_size. On allocation addr_ready = !wr_mem. Non-stores get value_ready=0.
- Allocation:
  - Occurs when alloc_en && alloc_ready.
  - Writes entry[tail]; tail = (tail+1) mod ROB_SIZE.
  - alloc_tag = tail combinationally.
  - alloc_ready = (count < ROB_SIZE) || retiring this cycle. Retire-and-allocate while full is allowed.
- Store data capture at dispatch: if alloc_wr_mem && !alloc_value_valid && cdb_valid && cdb_tag == alloc_store_dep, capture cdb_value with value_ready=1 in the same cycle.
- CDB (cdb_valid, valid entries only):
  - Entry cdb_tag is a store: set addr, addr_ready.
  - Otherwise: set value, value_ready.
  - Every valid store with !value_ready and store_dep == cdb_tag also captures the value.
  - A CDB to an invalid entry is ignored.
- Head and retire:
  - head_ready = valid && value_ready && addr_ready.
  - Retire = commit && head_ready. Retire clears entry[head] and advances head mod ROB_SIZE. Same-cycle alloc to that slot wins.
- count next = count + alloc - retire. count never exceeds ROB_SIZE or underflows.
- Load check, combinational:
  - Scan from ld_check_tag-1 back to head, wrapping, over valid entries only.
  - ld_conflict=1 if any store has !addr_ready, or addr_ready && addr == ld_check_addr.
  - If the load is at head or invalid, ld_conflict=0.
- Flush:
  - Highest priority. All entries become invalid and head=tail=count=0 next cycle.
  - Alloc, CDB and commit in the same cycle are discarded.
  - Flush with reset behaves as reset.
- Reads are combinational from the current entry state. No CDB bypass on rd_* (the map table handles bypass).

Optional Feature:
ROB_STLF_EN:
- When defined, adds outputs ld_fwd_valid (1) and ld_fwd_value (XLEN).
- The youngest older store with addr_ready, addr == ld_check_addr, matching mem_size and value_ready forwards its value. In that case ld_fwd_valid=1 and ld_conflict=0, unless a still-older-than-load store with unknown address lies between it and the load.
- When undefined, the ports are absent and ld_conflict behaves as above.

Test Plan:
1. Reset, then 8 allocs, no commit -> tags 0..7, count=8, alloc_ready=0. A 9th alloc_en is ignored (tail stays 0).
2. Full ROB, head value_ready, commit=1 and alloc_en=1 in the same cycle -> head=1, new entry at tag 0, count stays 8.
3. Store alloc with store_dep=3 while cdb_valid and cdb_tag=3, value 0xDEAD -> store value_ready=1, value=0xDEAD next cycle.
4. Store at tag 2 with addr 0x100 ready, load at tag 4, ld_check_addr=0x100 -> ld_conflict=1. With 0x104 -> 0. With the store address unknown -> 1.
5. Wrap: run 20 alloc/commit pairs -> tags cycle 0..7 and no entry is lost. count returns to 0 and empty=1.
6. Flush with 5 entries pending and simultaneous alloc and CDB -> next cycle count=0, empty=1, head_valid=0, alloc_tag=0.
